control_unit: RTL and testbench

- Multicycle control FSM for the MIPS-subset CPU.
- Takes the instruction fields from the IR and the status flags from the ULA, and drives every selector, operation code and write enable of the datapath.
- Sits beside the datapath top level. It is the driving end of the control bus that the datapath consumes.

---
 rtl/control_unit_if.sv | 45 ++++
 rtl/control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_control_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control bus between the multicycle control FSM and the datapath.
// The control unit is the master: it receives IR fields and ALU flags,
// and drives every datapath select, operation code and write enable.
interface control_unit_if;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       overflow;
  logic       EQ;
  logic [2:0] IorD;
  logic [1:0] EXCPCtrl;
  logic [1:0] RegDst;
  logic [3:0] DataSrc;
  logic [1:0] SHIFTAmt;
  logic       SHIFTSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] SHIFTOp;
  logic [2:0] ALUOp;
  logic [1:0] LSCtrl;
  logic [1:0] SSCtrl;
  logic       PCWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUOutWrite;
  logic       EPCWrite;
  logic       RegAWrite;
  logic       RegBWrite;
  logic       MDRWrite;

  modport master (
    input  OPCODE, FUNCT, overflow, EQ,
    output IorD, EXCPCtrl, RegDst, DataSrc, SHIFTAmt, SHIFTSrc, ALUSrcA, ALUSrcB,
           PCSrc, SHIFTOp, ALUOp, LSCtrl, SSCtrl, PCWrite, MemWrite, IRWrite,
           RegWrite, ALUOutWrite, EPCWrite, RegAWrite, RegBWrite, MDRWrite
  );

  modport slave (
    output OPCODE, FUNCT, overflow, EQ,
    input  IorD, EXCPCtrl, RegDst, DataSrc, SHIFTAmt, SHIFTSrc, ALUSrcA, ALUSrcB,
           PCSrc, SHIFTOp, ALUOp, LSCtrl, SSCtrl, PCWrite, MemWrite, IRWrite,
           RegWrite, ALUOutWrite, EPCWrite, RegAWrite, RegBWrite, MDRWrite
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset CPU. Outputs are a pure
// decode of the current state (plus EQ in the branch states); a reset
// held high forces the decode to the all-zero RESET pattern immediately.
module control_unit #(
  parameter int STATE_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master cu
);

  localparam logic [STATE_W-1:0] S_RESET   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH0  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_FETCH1  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_FETCH2  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_EX_ADD  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EX_SUB  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EX_AND  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_EX_ADDI = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_WB_RD   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_WB_RT   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_SLT     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_SH_LD   = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_SH_SLL  = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_SH_SRL  = STATE_W'(14);
  localparam logic [STATE_W-1:0] S_SH_WB   = STATE_W'(15);
  localparam logic [STATE_W-1:0] S_JR      = STATE_W'(16);
  localparam logic [STATE_W-1:0] S_LUI     = STATE_W'(17);
  localparam logic [STATE_W-1:0] S_BEQ     = STATE_W'(18);
  localparam logic [STATE_W-1:0] S_BNE     = STATE_W'(19);
  localparam logic [STATE_W-1:0] S_ADDR    = STATE_W'(20);
  localparam logic [STATE_W-1:0] S_LW0     = STATE_W'(21);
  localparam logic [STATE_W-1:0] S_LW1     = STATE_W'(22);
  localparam logic [STATE_W-1:0] S_LW2     = STATE_W'(23);
  localparam logic [STATE_W-1:0] S_LW_WB   = STATE_W'(24);
  localparam logic [STATE_W-1:0] S_SW0     = STATE_W'(25);
  localparam logic [STATE_W-1:0] S_SW1     = STATE_W'(26);
  localparam logic [STATE_W-1:0] S_SW2     = STATE_W'(27);
  localparam logic [STATE_W-1:0] S_SW3     = STATE_W'(28);
  localparam logic [STATE_W-1:0] S_J       = STATE_W'(29);
  localparam logic [STATE_W-1:0] S_JAL0    = STATE_W'(30);
  localparam logic [STATE_W-1:0] S_JAL1    = STATE_W'(31);
  localparam logic [STATE_W-1:0] S_EXC_EPC = STATE_W'(32);
  localparam logic [STATE_W-1:0] S_EXC0    = STATE_W'(33);
  localparam logic [STATE_W-1:0] S_EXC1    = STATE_W'(34);
  localparam logic [STATE_W-1:0] S_EXC2    = STATE_W'(35);
  localparam logic [STATE_W-1:0] S_EXC_PC  = STATE_W'(36);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [STATE_W-1:0] w_dec_state;
  logic               r_ovf_exc;   // exception cause: 1 overflow, 0 opcode

  // State register; also latches the exception cause on entry to EXC_EPC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RESET;
      r_ovf_exc <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == S_EXC_EPC) begin
        r_ovf_exc <= (r_state != S_DECODE);
      end
    end
  end

  // Next-state logic: linear sequences plus dispatch on the IR fields
  always_comb begin
    w_next_state = S_RESET;
    case (r_state)
      S_RESET:  w_next_state = S_FETCH0;
      S_FETCH0: w_next_state = S_FETCH1;
      S_FETCH1: w_next_state = S_FETCH2;
      S_FETCH2: w_next_state = S_DECODE;
      S_DECODE: begin
        case (cu.OPCODE)
          6'h00: begin
            case (cu.FUNCT)
              6'h20:        w_next_state = S_EX_ADD;
              6'h22:        w_next_state = S_EX_SUB;
              6'h24:        w_next_state = S_EX_AND;
              6'h2A:        w_next_state = S_SLT;
              6'h00, 6'h02: w_next_state = S_SH_LD;
              6'h08:        w_next_state = S_JR;
              default:      w_next_state = S_EXC_EPC;
            endcase
          end
          6'h08:        w_next_state = S_EX_ADDI;
          6'h0F:        w_next_state = S_LUI;
          6'h04:        w_next_state = S_BEQ;
          6'h05:        w_next_state = S_BNE;
          6'h23, 6'h2B: w_next_state = S_ADDR;
          6'h02:        w_next_state = S_J;
          6'h03:        w_next_state = S_JAL0;
          default:      w_next_state = S_EXC_EPC;
        endcase
      end
      S_EX_ADD, S_EX_SUB: w_next_state = cu.overflow ? S_EXC_EPC : S_WB_RD;
      S_EX_ADDI:          w_next_state = cu.overflow ? S_EXC_EPC : S_WB_RT;
      S_EX_AND:           w_next_state = S_WB_RD;
      S_SH_LD:            w_next_state = (cu.FUNCT == 6'h02) ? S_SH_SRL : S_SH_SLL;
      S_SH_SLL, S_SH_SRL: w_next_state = S_SH_WB;
      S_ADDR:             w_next_state = (cu.OPCODE == 6'h2B) ? S_SW0 : S_LW0;
      S_LW0:              w_next_state = S_LW1;
      S_LW1:              w_next_state = S_LW2;
      S_LW2:              w_next_state = S_LW_WB;
      S_SW0:              w_next_state = S_SW1;
      S_SW1:              w_next_state = S_SW2;
      S_SW2:              w_next_state = S_SW3;
      S_JAL0:             w_next_state = S_JAL1;
      S_EXC_EPC:          w_next_state = S_EXC0;
      S_EXC0:             w_next_state = S_EXC1;
      S_EXC1:             w_next_state = S_EXC2;
      S_EXC2:             w_next_state = S_EXC_PC;
      S_WB_RD, S_WB_RT, S_SLT, S_SH_WB, S_JR, S_LUI, S_BEQ, S_BNE,
      S_LW_WB, S_SW3, S_J, S_JAL1, S_EXC_PC: w_next_state = S_FETCH0;
      default:            w_next_state = S_RESET;
    endcase
  end

  // Output decode; a high reset selects the all-zero RESET pattern at once
  always_comb begin
    w_dec_state    = reset ? S_RESET : r_state;
    cu.IorD        = 3'b000;
    cu.EXCPCtrl    = 2'b00;
    cu.RegDst      = 2'b00;
    cu.DataSrc     = 4'b0000;
    cu.SHIFTAmt    = 2'b00;
    cu.SHIFTSrc    = 1'b0;
    cu.ALUSrcA     = 2'b00;
    cu.ALUSrcB     = 2'b00;
    cu.PCSrc       = 2'b00;
    cu.SHIFTOp     = 3'b000;
    cu.ALUOp       = 3'b000;
    cu.LSCtrl      = 2'b00;
    cu.SSCtrl      = 2'b00;
    cu.PCWrite     = 1'b0;
    cu.MemWrite    = 1'b0;
    cu.IRWrite     = 1'b0;
    cu.RegWrite    = 1'b0;
    cu.ALUOutWrite = 1'b0;
    cu.EPCWrite    = 1'b0;
    cu.RegAWrite   = 1'b0;
    cu.RegBWrite   = 1'b0;
    cu.MDRWrite    = 1'b0;
    case (w_dec_state)
      S_FETCH0, S_FETCH1: begin
        cu.ALUSrcB = 2'b01; cu.ALUOp = 3'b001;
      end
      S_FETCH2: begin
        cu.ALUSrcB = 2'b01; cu.ALUOp = 3'b001;
        cu.IRWrite = 1'b1; cu.PCWrite = 1'b1;
      end
      S_DECODE: begin
        cu.RegAWrite = 1'b1; cu.RegBWrite = 1'b1;
        cu.ALUSrcB = 2'b11; cu.ALUOp = 3'b001; cu.ALUOutWrite = 1'b1;
      end
      S_EX_ADD:  begin cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b001; cu.ALUOutWrite = 1'b1; end
      S_EX_SUB:  begin cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b010; cu.ALUOutWrite = 1'b1; end
      S_EX_AND:  begin cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b011; cu.ALUOutWrite = 1'b1; end
      S_EX_ADDI, S_ADDR: begin
        cu.ALUSrcA = 2'b01; cu.ALUSrcB = 2'b10; cu.ALUOp = 3'b001; cu.ALUOutWrite = 1'b1;
      end
      S_WB_RD:   begin cu.RegDst = 2'b01; cu.RegWrite = 1'b1; end
      S_WB_RT:   begin cu.RegDst = 2'b00; cu.RegWrite = 1'b1; end
      S_SLT: begin
        cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b111;
        cu.RegDst = 2'b01; cu.DataSrc = 4'b0101; cu.RegWrite = 1'b1;
      end
      S_SH_LD:   begin cu.SHIFTSrc = 1'b0; cu.SHIFTOp = 3'b001; end
      S_SH_SLL:  begin cu.SHIFTAmt = 2'b10; cu.SHIFTOp = 3'b010; end
      S_SH_SRL:  begin cu.SHIFTAmt = 2'b10; cu.SHIFTOp = 3'b011; end
      S_SH_WB:   begin cu.DataSrc = 4'b0110; cu.RegDst = 2'b01; cu.RegWrite = 1'b1; end
      S_JR:      begin cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b000; cu.PCWrite = 1'b1; end
      S_LUI:     begin cu.DataSrc = 4'b0100; cu.RegWrite = 1'b1; end
      S_BEQ: begin
        cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b111; cu.PCSrc = 2'b01; cu.PCWrite = cu.EQ;
      end
      S_BNE: begin
        cu.ALUSrcA = 2'b01; cu.ALUOp = 3'b111; cu.PCSrc = 2'b01; cu.PCWrite = ~cu.EQ;
      end
      S_LW0, S_LW1, S_SW0, S_SW1: cu.IorD = 3'b011;
      S_LW2, S_SW2: begin cu.IorD = 3'b011; cu.MDRWrite = 1'b1; end
      S_LW_WB:   begin cu.LSCtrl = 2'b01; cu.DataSrc = 4'b0001; cu.RegWrite = 1'b1; end
      S_SW3:     begin cu.IorD = 3'b011; cu.SSCtrl = 2'b01; cu.MemWrite = 1'b1; end
      S_J, S_JAL1: begin cu.PCSrc = 2'b10; cu.PCWrite = 1'b1; end
      S_JAL0:    begin cu.RegDst = 2'b10; cu.DataSrc = 4'b0111; cu.RegWrite = 1'b1; end
      S_EXC_EPC: begin
        cu.EXCPCtrl = {1'b0, r_ovf_exc};
        cu.ALUSrcB = 2'b01; cu.ALUOp = 3'b010; cu.EPCWrite = 1'b1;
      end
      S_EXC0, S_EXC1: begin cu.EXCPCtrl = {1'b0, r_ovf_exc}; cu.IorD = 3'b001; end
      S_EXC2: begin
        cu.EXCPCtrl = {1'b0, r_ovf_exc}; cu.IorD = 3'b001; cu.MDRWrite = 1'b1;
      end
      S_EXC_PC: begin
        cu.EXCPCtrl = {1'b0, r_ovf_exc};
        cu.LSCtrl = 2'b11; cu.PCSrc = 2'b11; cu.PCWrite = 1'b1;
      end
      default: cu.IorD = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction step model pushes
// the expected control word of every cycle; a monitor pops and compares
// one word at each falling edge.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] IorD;
    logic [1:0] EXCPCtrl;
    logic [1:0] RegDst;
    logic [3:0] DataSrc;
    logic [1:0] SHIFTAmt;
    logic       SHIFTSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] SHIFTOp;
    logic [2:0] ALUOp;
    logic [1:0] LSCtrl;
    logic [1:0] SSCtrl;
    logic       PCWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUOutWrite;
    logic       EPCWrite;
    logic       RegAWrite;
    logic       RegBWrite;
    logic       MDRWrite;
  } ctl_t;

  logic clk;
  logic reset;
  control_unit_if bus();

  control_unit #(.STATE_W(6)) dut (.clk(clk), .reset(reset), .cu(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ctl_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;

  function automatic ctl_t sample_bus();
    ctl_t a;
    a.IorD = bus.IorD;           a.EXCPCtrl = bus.EXCPCtrl;     a.RegDst = bus.RegDst;
    a.DataSrc = bus.DataSrc;     a.SHIFTAmt = bus.SHIFTAmt;     a.SHIFTSrc = bus.SHIFTSrc;
    a.ALUSrcA = bus.ALUSrcA;     a.ALUSrcB = bus.ALUSrcB;       a.PCSrc = bus.PCSrc;
    a.SHIFTOp = bus.SHIFTOp;     a.ALUOp = bus.ALUOp;           a.LSCtrl = bus.LSCtrl;
    a.SSCtrl = bus.SSCtrl;       a.PCWrite = bus.PCWrite;       a.MemWrite = bus.MemWrite;
    a.IRWrite = bus.IRWrite;     a.RegWrite = bus.RegWrite;     a.ALUOutWrite = bus.ALUOutWrite;
    a.EPCWrite = bus.EPCWrite;   a.RegAWrite = bus.RegAWrite;   a.RegBWrite = bus.RegBWrite;
    a.MDRWrite = bus.MDRWrite;
    return a;
  endfunction

  // Monitor: every falling edge with an outstanding expectation is checked
  always @(negedge clk) begin
    ctl_t e;
    ctl_t a;
    n_cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample_bus();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctl_word cycle %0d: got %h required %h (op=%h fn=%h ovf=%b eq=%b)",
                 n_cycle, a, e, bus.OPCODE, bus.FUNCT, bus.overflow, bus.EQ);
      end
    end
  end

  // ---------------- reference model: expected per-cycle control words ----------------
  task automatic exc_seq(input logic [1:0] cause);
    ctl_t c;
    c = '0; c.EXCPCtrl = cause; c.ALUSrcB = 2'b01; c.ALUOp = 3'b010; c.EPCWrite = 1'b1;
    exp_q.push_back(c);
    c = '0; c.EXCPCtrl = cause; c.IorD = 3'b001;
    exp_q.push_back(c); exp_q.push_back(c);
    c.MDRWrite = 1'b1;
    exp_q.push_back(c);
    c = '0; c.EXCPCtrl = cause; c.LSCtrl = 2'b11; c.PCSrc = 2'b11; c.PCWrite = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic arith_seq(input logic [1:0] srcb, input logic [2:0] op, input logic chk,
                           input logic to_rd, input logic ovf);
    ctl_t c;
    c = '0; c.ALUSrcA = 2'b01; c.ALUSrcB = srcb; c.ALUOp = op; c.ALUOutWrite = 1'b1;
    exp_q.push_back(c);
    if (chk && ovf) begin
      exc_seq(2'b01);
    end else begin
      c = '0; c.RegDst = to_rd ? 2'b01 : 2'b00; c.RegWrite = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  task automatic mem_seq(input logic is_sw);
    ctl_t c;
    c = '0; c.ALUSrcA = 2'b01; c.ALUSrcB = 2'b10; c.ALUOp = 3'b001; c.ALUOutWrite = 1'b1;
    exp_q.push_back(c);
    c = '0; c.IorD = 3'b011;
    exp_q.push_back(c); exp_q.push_back(c);
    c.MDRWrite = 1'b1;
    exp_q.push_back(c);
    c = '0;
    if (is_sw) begin
      c.IorD = 3'b011; c.SSCtrl = 2'b01; c.MemWrite = 1'b1;
    end else begin
      c.LSCtrl = 2'b01; c.DataSrc = 4'b0001; c.RegWrite = 1'b1;
    end
    exp_q.push_back(c);
  endtask

  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic eq);
    ctl_t c;
    c = '0; c.ALUSrcB = 2'b01; c.ALUOp = 3'b001;
    exp_q.push_back(c); exp_q.push_back(c);
    c.IRWrite = 1'b1; c.PCWrite = 1'b1;
    exp_q.push_back(c);
    c = '0; c.RegAWrite = 1'b1; c.RegBWrite = 1'b1; c.ALUSrcB = 2'b11; c.ALUOp = 3'b001;
    c.ALUOutWrite = 1'b1;
    exp_q.push_back(c);
    c = '0;
    if (op == 6'h00) begin
      if (fn == 6'h20)      arith_seq(2'b00, 3'b001, 1'b1, 1'b1, ovf);
      else if (fn == 6'h22) arith_seq(2'b00, 3'b010, 1'b1, 1'b1, ovf);
      else if (fn == 6'h24) arith_seq(2'b00, 3'b011, 1'b0, 1'b1, ovf);
      else if (fn == 6'h2A) begin
        c.ALUSrcA = 2'b01; c.ALUOp = 3'b111; c.RegDst = 2'b01; c.DataSrc = 4'b0101;
        c.RegWrite = 1'b1; exp_q.push_back(c);
      end else if (fn == 6'h00 || fn == 6'h02) begin
        c.SHIFTOp = 3'b001; exp_q.push_back(c);
        c = '0; c.SHIFTAmt = 2'b10; c.SHIFTOp = (fn == 6'h02) ? 3'b011 : 3'b010;
        exp_q.push_back(c);
        c = '0; c.DataSrc = 4'b0110; c.RegDst = 2'b01; c.RegWrite = 1'b1; exp_q.push_back(c);
      end else if (fn == 6'h08) begin
        c.ALUSrcA = 2'b01; c.PCWrite = 1'b1; exp_q.push_back(c);
      end else exc_seq(2'b00);
    end
    else if (op == 6'h08) arith_seq(2'b10, 3'b001, 1'b1, 1'b0, ovf);
    else if (op == 6'h0F) begin c.DataSrc = 4'b0100; c.RegWrite = 1'b1; exp_q.push_back(c); end
    else if (op == 6'h04 || op == 6'h05) begin
      c.ALUSrcA = 2'b01; c.ALUOp = 3'b111; c.PCSrc = 2'b01;
      c.PCWrite = (op == 6'h04) ? eq : ~eq;
      exp_q.push_back(c);
    end
    else if (op == 6'h23) mem_seq(1'b0);
    else if (op == 6'h2B) mem_seq(1'b1);
    else if (op == 6'h02) begin c.PCSrc = 2'b10; c.PCWrite = 1'b1; exp_q.push_back(c); end
    else if (op == 6'h03) begin
      c.RegDst = 2'b10; c.DataSrc = 4'b0111; c.RegWrite = 1'b1; exp_q.push_back(c);
      c = '0; c.PCSrc = 2'b10; c.PCWrite = 1'b1; exp_q.push_back(c);
    end
    else exc_seq(2'b00);
  endtask

  // ---------------- stimulus ----------------
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                           input logic eq);
    int n0;
    int n;
    bus.OPCODE = op; bus.FUNCT = fn; bus.overflow = ovf; bus.EQ = eq;
    n0 = exp_q.size();
    model(op, fn, ovf, eq);
    n = exp_q.size() - n0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
                              6'h0F, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h3F};
  logic [5:0] fn_tab [16] = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    ctl_t z;
    z = '0;
    reset = 1'b1;
    bus.OPCODE = 6'h00; bus.FUNCT = 6'h00; bus.overflow = 1'b0; bus.EQ = 1'b0;
    @(posedge clk); #1;
    // two reset-high cycles, then the RESET cycle with reset low
    exp_q.push_back(z); @(posedge clk); #1;
    exp_q.push_back(z); @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(z); @(posedge clk); #1;

    // directed cases
    run_instr(6'h00, 6'h20, 1'b0, 1'b0);   // add $3,$1,$2
    run_instr(6'h00, 6'h20, 1'b1, 1'b0);   // add with overflow
    run_instr(6'h04, 6'h00, 1'b0, 1'b1);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 1'b0);   // beq not taken
    run_instr(6'h05, 6'h00, 1'b0, 1'b1);   // bne not taken
    run_instr(6'h05, 6'h00, 1'b0, 1'b0);   // bne taken
    run_instr(6'h23, 6'h00, 1'b0, 1'b0);   // lw
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0);   // sw
    run_instr(6'h3F, 6'h00, 1'b1, 1'b1);   // opcode exception
    run_instr(6'h08, 6'h00, 1'b1, 1'b0);   // addi overflow
    run_instr(6'h00, 6'h3F, 1'b0, 1'b0);   // bad funct

    // reset raised during LW1: lw runs 6 cycles, then zeros through RESET
    bus.OPCODE = 6'h23; bus.FUNCT = 6'h00; bus.overflow = 1'b0; bus.EQ = 1'b0;
    model(6'h23, 6'h00, 1'b0, 1'b0);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    exp_q.push_back(z);
    exp_q.push_back(z);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_instr(6'h00, 6'h24, 1'b0, 1'b0);   // and restarts cleanly from FETCH0

    // randomized instruction mix, including arbitrary encodings
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int k;
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end else begin
        k  = $urandom_range(0, 15);
        op = op_tab[k];
        fn = fn_tab[k];
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
